// File: rtl/vga_image_scanner.sv
// vga_image_scanner: 640x480@60-style VGA raster generator that reads a 12-bit
// image ROM in raster order and drives 4:4:4 RGB plus active-low syncs.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   rom_addr_o     registered ROM read address (v*IMG_W + h inside the image)
//   rom_dout_i     ROM data, valid one clock after rom_addr_o
//   vga_r/g/b_o    colour channels, black in blanking, BG_COLOR outside image
//   vga_hs_o       HSYNC, active low
//   vga_vs_o       VSYNC, active low
//   frame_start_o  one-clock pulse on the edge the counters enter (0,0)
//
// Latency: counter state reaches the pins two clocks later (ROM read + output
// register). Both stages run every clock, independent of the pixel tick.
module vga_image_scanner #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 12,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_dout_i,
  output logic [3:0]            vga_r_o,
  output logic [3:0]            vga_g_o,
  output logic [3:0]            vga_b_o,
  output logic                  vga_hs_o,
  output logic                  vga_vs_o,
  output logic                  frame_start_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [HW-1:0]   HLast   = HW'(HTotal - 1);
  localparam logic [HW-1:0]   HActive = HW'(H_ACTIVE);
  localparam logic [HW-1:0]   ImgW    = HW'(IMG_W);
  localparam logic [HW-1:0]   HsFirst = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]   HsLast  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]   VLast   = VW'(VTotal - 1);
  localparam logic [VW-1:0]   VActive = VW'(V_ACTIVE);
  localparam logic [VW-1:0]   ImgH    = VW'(IMG_H);
  localparam logic [VW-1:0]   VsFirst = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]   VsLast  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DivW-1:0]       div_q, div_d;
  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  frame_start_q, frame_start_d;
  logic                  pix_tick;

  // Stage-0 flags and their one-clock-delayed copies aligned with rom_dout_i.
  logic active_s, in_img_s, hs_n_s, vs_n_s;
  logic active_d1_q, in_img_d1_q, hs_n_d1_q, vs_n_d1_q;

  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, vs_q;

  assign pix_tick = (div_q == DivMax);

  always_comb begin
    div_d         = pix_tick ? '0 : div_q + 1'b1;
    h_d           = h_q;
    v_d           = v_q;
    rom_addr_d    = rom_addr_q;
    frame_start_d = 1'b0;
    if (pix_tick) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      // The address tracks the position being entered, so raster order inside
      // the window is a plain increment and blanking simply holds it.
      if (h_d == '0 && v_d == '0) begin
        rom_addr_d    = '0;
        frame_start_d = 1'b1;
      end else if (h_d < ImgW && v_d < ImgH) begin
        rom_addr_d = rom_addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    active_s = (h_q < HActive) && (v_q < VActive);
    in_img_s = (h_q < ImgW) && (v_q < ImgH);
    hs_n_s   = !((h_q >= HsFirst) && (h_q <= HsLast));
    vs_n_s   = !((v_q >= VsFirst) && (v_q <= VsLast));
  end

  always_comb begin
    rgb_d = 12'h000;
    if (active_d1_q) begin
      rgb_d = in_img_d1_q ? rom_dout_i[11:0] : BG_COLOR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      rom_addr_q    <= '0;
      frame_start_q <= 1'b0;
      active_d1_q   <= 1'b0;
      in_img_d1_q   <= 1'b0;
      hs_n_d1_q     <= 1'b1;
      vs_n_d1_q     <= 1'b1;
      rgb_q         <= 12'h000;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      rom_addr_q    <= rom_addr_d;
      frame_start_q <= frame_start_d;
      active_d1_q   <= active_s;
      in_img_d1_q   <= in_img_s;
      hs_n_d1_q     <= hs_n_s;
      vs_n_d1_q     <= vs_n_s;
      rgb_q         <= rgb_d;
      hs_q          <= hs_n_d1_q;
      vs_q          <= vs_n_d1_q;
    end
  end

  assign rom_addr_o    = rom_addr_q;
  assign vga_r_o       = rgb_q[11:8];
  assign vga_g_o       = rgb_q[7:4];
  assign vga_b_o       = rgb_q[3:0];
  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_image_scanner.sv
// Bench for vga_image_scanner with a shrunken raster so several frames fit in
// a short run. The expected outputs for every clock are derived in closed form
// from the number of clocks since reset release.
module tb_vga_image_scanner;

  localparam int unsigned D     = 3;
  localparam int unsigned HA    = 16;
  localparam int unsigned HFP   = 2;
  localparam int unsigned HS    = 3;
  localparam int unsigned HBP   = 3;
  localparam int unsigned VA    = 8;
  localparam int unsigned VFP   = 2;
  localparam int unsigned VS    = 2;
  localparam int unsigned VBP   = 2;
  localparam int unsigned IW    = 12;
  localparam int unsigned IH    = 6;
  localparam logic [11:0] BG    = 12'h00F;
  localparam int unsigned HT    = HA + HFP + HS + HBP;
  localparam int unsigned VT    = VA + VFP + VS + VBP;
  localparam int unsigned FRAME = D * HT * VT;

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [18:0] rom_addr;
  logic [11:0] rom_dout;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned k        = 0;
  bit          started  = 1'b0;
  logic [11:0] salt;
  exp_t        exp_q[$];

  vga_image_scanner #(
    .CLK_DIV (D),  .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP),    .V_SYNC(VS), .V_BP(VBP),
    .IMG_W   (IW), .IMG_H(IH),    .ADDR_WIDTH(19), .DATA_WIDTH(12), .BG_COLOR(BG)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rom_addr_o   (rom_addr),
    .rom_dout_i   (rom_dout),
    .vga_r_o      (vga_r),
    .vga_g_o      (vga_g),
    .vga_b_o      (vga_b),
    .vga_hs_o     (vga_hs),
    .vga_vs_o     (vga_vs),
    .frame_start_o(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Screen position after k clocks since release.
  function automatic void pos_of(input int unsigned kk, output int unsigned h,
                                 output int unsigned v);
    int unsigned p;
    p = (kk / D) % (HT * VT);
    h = p % HT;
    v = p / HT;
  endfunction

  function automatic bit in_img(input int unsigned h, input int unsigned v);
    return (h < IW) && (v < IH);
  endfunction

  // Address is the raster index of the most recent image pixel in this frame.
  function automatic int unsigned addr_of(input int unsigned h, input int unsigned v);
    if (in_img(h, v)) return v * IW + h;
    if (v < IH) return v * IW + IW - 1;
    return IW * IH - 1;
  endfunction

  function automatic logic [11:0] mem_of(input int unsigned a);
    return 12'(a) ^ salt;
  endfunction

  function automatic exp_t expect_at(input int unsigned kk);
    exp_t        e;
    int unsigned h, v;
    pos_of(kk, h, v);
    e.addr = 19'(addr_of(h, v));
    e.fs   = (kk > 0) && (kk % FRAME == 0);
    e.rgb  = 12'h000;
    e.hs   = 1'b1;
    e.vs   = 1'b1;
    if (kk >= 2) begin
      pos_of(kk - 2, h, v);
      if (h < HA && v < VA) e.rgb = in_img(h, v) ? mem_of(addr_of(h, v)) : BG;
      e.hs = !(h >= HA + HFP && h <= HA + HFP + HS - 1);
      e.vs = !(v >= VA + VFP && v <= VA + VFP + VS - 1);
    end
    return e;
  endfunction

  // ROM model plus expectation producer. Outside the image the ROM returns
  // junk so that any use of blanking data shows up on the pins.
  always @(posedge clk) begin
    int unsigned h, v;
    if (!rst_n) begin
      rom_dout <= 12'($urandom);
      k = 0;
    end else begin
      pos_of(k, h, v);
      if (in_img(h, v)) rom_dout <= mem_of(int'(rom_addr));
      else rom_dout <= ($urandom_range(0, 1) != 0) ? 12'hFFF : 12'($urandom);
      k = k + 1;
    end
    exp_q.push_back(expect_at(k));
    started = 1'b1;
  end

  // Monitor: compares the pins against the queued expectation every clock.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rom_addr", {13'b0, rom_addr}, {13'b0, e.addr});
      check("rgb_hs_vs", {18'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs},
            {18'b0, e.rgb, e.hs, e.vs});
      check("frame_start", {31'b0, frame_start}, {31'b0, e.fs});
    end else if (started) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end
  end

  task automatic measure_low(input bit is_vs, input int unsigned bound,
                             output int unsigned low, output int unsigned high);
    int unsigned n;
    n = 0;
    while (((is_vs ? vga_vs : vga_hs) !== 1'b1) && n < bound) begin @(posedge clk); #1; n++; end
    n = 0;
    while (((is_vs ? vga_vs : vga_hs) !== 1'b0) && n < bound) begin @(posedge clk); #1; n++; end
    low = 0;
    while (((is_vs ? vga_vs : vga_hs) === 1'b0) && low < bound) begin @(posedge clk); #1; low++; end
    high = 0;
    while (((is_vs ? vga_vs : vga_hs) === 1'b1) && high < bound) begin @(posedge clk); #1; high++; end
  endtask

  initial begin
    int unsigned cnt, low, high;
    rst_n    = 1'b0;
    rom_dout = 12'h000;
    salt     = 12'($urandom);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b1;

    // Run into the third frame, then reset inside the image window.
    repeat (2 * FRAME + (3 * HT + 8) * D) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rgb", {20'b0, vga_r, vga_g, vga_b}, 32'd0);
    check("async_rst_sync", {30'b0, vga_hs, vga_vs}, 32'd3);
    check("async_rst_fs", {31'b0, frame_start}, 32'd0);
    check("async_rst_addr", {13'b0, rom_addr}, 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (frame_start !== 1'b1 && cnt < 3 * FRAME);
    check("frame_after_reset", cnt, FRAME);

    measure_low(1'b0, 2 * FRAME, low, high);
    check("hs_low_width", low, HS * D);
    check("hs_high_width", high, (HT - HS) * D);
    measure_low(1'b1, 3 * FRAME, low, high);
    check("vs_low_width", low, VS * HT * D);
    check("vs_high_width", high, (VT - VS) * HT * D);

    repeat (FRAME / 2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(40 * FRAME * 10);
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
